// File: rtl/target_bbox_locate.sv
// rtl/target_bbox_locate.sv - colour-threshold target bounding-box locator for an RGB pixel stream
// Publishes exclusive window bounds for the previous frame two cycles after each frame start.
module target_bbox_locate #(
  parameter logic [7:0] R_MIN     = 8'd160,
  parameter logic [7:0] G_MAX     = 8'd100,
  parameter logic [7:0] B_MAX     = 8'd100,
  parameter int         MIN_RUN   = 4,
  parameter int         MIN_COUNT = 64,
  parameter int         MARGIN    = 1,
  parameter logic       VS_POL    = 1'b1
) (
  input  logic        pixelclk,
  input  logic        reset_n,
  input  logic [23:0] i_rgb,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_de,
  input  logic [11:0] hcount,
  input  logic [11:0] vcount,
  output logic [11:0] hcount_l,
  output logic [11:0] hcount_r,
  output logic [11:0] vcount_l,
  output logic [11:0] vcount_r,
  output logic        o_valid,
  output logic        o_frame_done
);

  localparam logic [3:0]  RUN_LAST  = 4'(MIN_RUN - 1);
  localparam logic [11:0] RUN_BACK  = 12'(MIN_RUN - 1);
  localparam logic [21:0] RUN_LEN   = 22'(MIN_RUN);
  localparam logic [21:0] CNT_MIN   = 22'(MIN_COUNT);
  localparam logic [11:0] MARGIN_12 = 12'(MARGIN);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_LATCH} state_e;

  state_e      state_q;
  logic        vs_q;
  logic [3:0]  run_q;
  logic [11:0] xmin_q, xmax_q, ymin_q, ymax_q;
  logic [11:0] xmin_d, xmax_d, ymin_d, ymax_d;
  logic [21:0] cnt_q, cnt_d;
  logic [22:0] cnt_sum;
  logic [11:0] x_start;
  logic        fs, target, qual, qual_first;

  // hsync is carried only as a timing reference for the surrounding pipeline
  logic unused_hsync;
  assign unused_hsync = i_hsync;

  assign fs     = (i_vsync == VS_POL) && (vs_q != VS_POL);
  assign target = i_de && (i_rgb[23:16] > R_MIN) && (i_rgb[15:8] < G_MAX)
                       && (i_rgb[7:0] < B_MAX);
  assign qual       = target && (run_q >= RUN_LAST);
  assign qual_first = target && (run_q == RUN_LAST);

  function automatic logic [11:0] lo_bound(input logic [11:0] v);
    return (v < MARGIN_12) ? 12'd0 : v - MARGIN_12;
  endfunction

  function automatic logic [11:0] hi_bound(input logic [11:0] v);
    logic [12:0] s;
    s = {1'b0, v} + {1'b0, MARGIN_12};
    return s[12] ? 12'hFFF : s[11:0];
  endfunction

  // Run start is credited at the qualifying pixel, so the left edge reaches back MIN_RUN-1.
  always_comb begin
    x_start = hcount - RUN_BACK;
    xmin_d  = (qual_first && (x_start < xmin_q)) ? x_start : xmin_q;
    xmax_d  = (hcount > xmax_q) ? hcount : xmax_q;
    ymin_d  = (vcount < ymin_q) ? vcount : ymin_q;
    ymax_d  = (vcount > ymax_q) ? vcount : ymax_q;
    cnt_sum = {1'b0, cnt_q} + {1'b0, (qual_first ? RUN_LEN : 22'd1)};
    cnt_d   = cnt_sum[22] ? {22{1'b1}} : cnt_sum[21:0];
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      vs_q         <= 1'b0;
      run_q        <= 4'd0;
      xmin_q       <= 12'hFFF;
      ymin_q       <= 12'hFFF;
      xmax_q       <= 12'd0;
      ymax_q       <= 12'd0;
      cnt_q        <= 22'd0;
      hcount_l     <= 12'd0;
      hcount_r     <= 12'd0;
      vcount_l     <= 12'd0;
      vcount_r     <= 12'd0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      vs_q         <= i_vsync;
      o_frame_done <= 1'b0;
      // Saturate so very long runs keep qualifying instead of wrapping to zero
      if (target) begin
        run_q <= (run_q == 4'hF) ? run_q : run_q + 4'd1;
      end else begin
        run_q <= 4'd0;
      end
      case (state_q)
        S_IDLE: begin
          if (fs) begin
            state_q <= S_ACCUM;
            xmin_q  <= 12'hFFF;
            ymin_q  <= 12'hFFF;
            xmax_q  <= 12'd0;
            ymax_q  <= 12'd0;
            cnt_q   <= 22'd0;
          end
        end
        S_ACCUM: begin
          if (fs) begin
            state_q <= S_LATCH;
          end else if (qual) begin
            xmin_q <= xmin_d;
            xmax_q <= xmax_d;
            ymin_q <= ymin_d;
            ymax_q <= ymax_d;
            cnt_q  <= cnt_d;
          end
        end
        S_LATCH: begin
          if (cnt_q >= CNT_MIN) begin
            hcount_l <= lo_bound(xmin_q);
            hcount_r <= hi_bound(xmax_q);
            vcount_l <= lo_bound(ymin_q);
            vcount_r <= hi_bound(ymax_q);
            o_valid  <= 1'b1;
          end else begin
            o_valid  <= 1'b0;
          end
          o_frame_done <= 1'b1;
          xmin_q       <= 12'hFFF;
          ymin_q       <= 12'hFFF;
          xmax_q       <= 12'd0;
          ymax_q       <= 12'd0;
          cnt_q        <= 22'd0;
          run_q        <= 4'd0;
          state_q      <= S_ACCUM;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
